// File: rtl/sel_demux_pkg.sv
// Shared types and helpers for the select-driven dispatch demux.
// State encoding, select legality and saturating count arithmetic.
package sel_demux_pkg;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic logic is_legal_sel(
    input logic [31:0] sel,
    input int          n
  );
    return sel < 32'(n);
  endfunction

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max
  );
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/sel_demux_dispatch_if.sv
// Upstream valid/ready request and per-channel downstream bundle.
// master drives requests and channel readies; slave is the demux.
interface sel_demux_dispatch_if #(
  parameter int NUM_OUT = 3,
  parameter int SEL_W   = 2,
  parameter int DATA_W  = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   in_sel;
  logic [DATA_W-1:0]  in_data;
  logic [NUM_OUT-1:0] out_valid;
  logic [NUM_OUT-1:0] out_ready;
  logic [DATA_W-1:0]  out_data;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sel_onehot_dec.sv
// Select code plus enable to one-hot channel vector.
// Flags enabled codes that name no channel.
module sel_onehot_dec
  import sel_demux_pkg::*;
#(
  parameter int NUM_OUT = 3,
  parameter int SEL_W   = 2
) (
  input  logic               en,
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] hot,
  output logic               illegal
);
  logic legal;

  assign legal = is_legal_sel(32'(sel), NUM_OUT);

  always_comb begin
    hot     = '0;
    illegal = 1'b0;
    unique case (1'b1)
      en && legal:  hot = NUM_OUT'(1) << sel;
      en && !legal: illegal = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/sel_demux_dispatch.sv
// Registered 1-to-NUM_OUT dispatch demux with a single holding entry.
// Illegal selects are consumed, flagged next cycle and counted.
module sel_demux_dispatch
  import sel_demux_pkg::*;
#(
  parameter int NUM_OUT   = 3,
  parameter int SEL_W     = 2,
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sel_demux_dispatch_if.slave  bus,
  output logic                 err_illegal,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);
  localparam logic [0:0] S_EMPTY = 1'(ST_EMPTY);
  localparam logic [0:0] S_FULL  = 1'(ST_FULL);
  localparam logic [31:0] ERR_MAX =
    32'((64'd1 << ERR_CNT_W) - 64'd1);

  generate
    if (NUM_OUT < 2 || NUM_OUT > (1 << SEL_W))
      $error("sel_demux_dispatch: NUM_OUT out of range for SEL_W");
    if (ERR_CNT_W < 1 || ERR_CNT_W > 31)
      $error("sel_demux_dispatch: ERR_CNT_W out of range");
  endgenerate

  logic [0:0]         state;
  logic [SEL_W-1:0]   hold_sel;
  logic [DATA_W-1:0]  hold_data;
  logic               full;
  logic               drain;
  logic               accept;
  logic               acc_ok;
  logic               in_bad;
  logic               out_bad;
  logic [NUM_OUT-1:0] in_hot;

  assign full         = state == S_FULL;
  assign drain        = |(bus.out_valid & bus.out_ready);
  assign bus.in_ready = !full || drain;
  assign accept       = bus.in_valid && bus.in_ready;
  assign acc_ok       = |in_hot;
  assign bus.out_data = hold_data;
  assign busy         = full;

  sel_onehot_dec #(
    .NUM_OUT(NUM_OUT),
    .SEL_W  (SEL_W)
  ) u_in_dec (
    .en     (accept),
    .sel    (bus.in_sel),
    .hot    (in_hot),
    .illegal(in_bad)
  );

  sel_onehot_dec #(
    .NUM_OUT(NUM_OUT),
    .SEL_W  (SEL_W)
  ) u_out_dec (
    .en     (full),
    .sel    (hold_sel),
    .hot    (bus.out_valid),
    .illegal(out_bad)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_EMPTY;
      hold_sel    <= '0;
      hold_data   <= '0;
      err_illegal <= 1'b0;
      err_count   <= '0;
    end else begin
      err_illegal <= in_bad;
      if (in_bad)
        err_count <= ERR_CNT_W'(sat_inc(32'(err_count), ERR_MAX));
      // a new legal word wins over drain, so FULL persists
      if (acc_ok) begin
        state     <= S_FULL;
        hold_sel  <= bus.in_sel;
        hold_data <= bus.in_data;
      end else if (drain) begin
        state <= S_EMPTY;
      end
    end
  end

`ifndef SYNTHESIS
  a_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(bus.out_valid));
  a_no_x_sel: assert property (@(posedge clk) disable iff (rst)
    !(bus.in_valid && $isunknown(bus.in_sel)));
  a_hold_legal: assert property (@(posedge clk) disable iff (rst)
    !out_bad);
  a_stable: assert property (@(posedge clk) disable iff (rst)
    (full && !drain) |=>
      (full && $stable(hold_sel) && $stable(hold_data)));
`endif
endmodule

// File: doc/sel_demux_dispatch.md
Name: sel_demux_dispatch

Overview:
- Registered 1-to-NUM_OUT demultiplexer. It is the dispatch-side counterpart of the select-driven output muxes used in the datapath.
- Accepts one valid/ready transaction carrying a select code and a data word, and forwards the word to exactly one destination channel.
- Checks that every select is legal (full-case) and that no more than one output is ever valid (unique) at run time.
- Illegal selects are dropped and counted.

Parameters:
- NUM_OUT, 3, number of destination channels; range 2..2**SEL_W.
- SEL_W, 2, width of the select code; must be >= clog2(NUM_OUT).
- DATA_W, 8, payload width.
- ERR_CNT_W, 8, width of the saturating illegal-select counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream transaction valid.
- in_ready  out  1  upstream may transfer this cycle.
- in_sel  in  SEL_W  destination code; legal range 0..NUM_OUT-1.
- in_data  in  DATA_W  payload.
- out_valid  out  NUM_OUT  per-destination valid; one-hot or zero.
- out_ready  in  NUM_OUT  per-destination ready.
- out_data  out  DATA_W  shared payload bus, qualified by out_valid.
- err_illegal  out  1  one-cycle pulse, one cycle after an illegal select is accepted.
- err_count  out  ERR_CNT_W  saturating count of illegal selects.
- busy  out  1  holding register occupied.

Behaviour:
- Reset and clocking:
  - One clock domain (clk); reset (rst) is synchronous and active-high.
  - On rst: state=EMPTY, out_valid=0, out_data=0, err_illegal=0, err_count=0, busy=0.
  - rst mid-transfer discards the held word with no error reported.
- Storage is a single holding entry {hold_sel, hold_data}, controlled by a 2-state FSM:
  - EMPTY -> FULL on a legal accept.
  - FULL -> EMPTY on drain with no new legal accept.
  - FULL -> FULL on drain plus a simultaneous legal accept, or on a stall.
- Handshake:
  - drain = (state==FULL) && out_ready[hold_sel].
  - in_ready = (state==EMPTY) || drain. It is combinational from out_ready.
  - accept = in_valid && in_ready.
  - Throughput is one word per clock when the target destination is ready.
- Latency: a word accepted in cycle N is presented on out_valid/out_data in cycle N+1.
- Outputs:
  - out_valid[i] = (state==FULL) && (hold_sel==i).
  - out_valid is never multi-hot. It is zero when EMPTY.
  - out_ready bits of non-selected channels are ignored.
- Stability: while out_valid[i]=1 and out_ready[i]=0, hold_sel and out_data stay constant.
- Legal accept: load in_sel and in_data into the holding register.
- Illegal accept (in_sel >= NUM_OUT):
  - The word is consumed (in_ready has already been granted) and not loaded.
  - err_illegal=1 in the next cycle.
  - err_count increments, saturating at all-ones with no wrap.
- Simultaneous drain plus illegal accept: state goes to EMPTY and err_illegal pulses.
- When NUM_OUT == 2**SEL_W, there is no illegal code; err_illegal stays 0 permanently.
- Back-to-back illegal selects: err_illegal stays high on consecutive cycles, and the count increments each cycle.
- out_data holds its last value when EMPTY; consumers must qualify it with out_valid.
- Simulation-only assertions:
  - $onehot0(out_valid).
  - No X on in_sel when in_valid=1.
  - Stability rule above.
  - SEL_W/NUM_OUT parameter legality, checked at elaboration.

Decomposition:
- Package sel_demux_pkg:
  - state enum {ST_EMPTY, ST_FULL}.
  - Function is_legal_sel(sel, n).
  - Function for the saturating increment.
- Sub-module sel_onehot_dec:
  - Purely combinational: SEL_W code + enable -> NUM_OUT one-hot vector, plus illegal flag.
  - Written as a unique case with a default; used for both out_valid and illegal detection.

Test Plan:
- Reset, then in_sel=1, in_data=8'hA5, out_ready=3'b111 -> next cycle out_valid=3'b010, out_data=8'hA5. One cycle later out_valid=0, busy=0.
- Stream sel 0,1,2,0 every cycle with all ready -> out_valid 001,010,100,001 on consecutive cycles; in_ready held 1 throughout.
- Hold sel=2, data=8'h3C with out_ready=3'b011 for 5 cycles -> out_valid=3'b100 and out_data=8'h3C stable, in_ready=0. Raise out_ready[2] -> drains in that cycle; in_ready=1 in the same cycle.
- in_sel=3 (NUM_OUT=3) with in_valid=1 -> in_ready=1, no out_valid, err_illegal pulses 1 cycle later, err_count=1. Repeat 300 times -> err_count saturates at 8'hFF.
- FULL with sel=0; in the same cycle assert out_ready[0] and an illegal in_sel=3 -> next cycle state EMPTY, out_valid=0, err_illegal=1.
- Assert rst while FULL and stalled -> next cycle out_valid=0, busy=0, err_count=0, in_ready=1, and no err_illegal pulse.
